cube_frame_stepper: RTL

//  Consumer end of the slow refresh clock: samples the toggling slow clock in the clk_50MHz

---
 rtl/cube_frame_stepper.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/cube_frame_stepper.sv
// -----------------------------------------------------------------------------
// cube_frame_stepper
//
// Consumer end of the slow refresh clock for the LED cube. The toggling slow
// clock is synchronised into the clk_50MHz domain, and each of its rising edges
// becomes a one-cycle frame-advance event. A small IDLE/RUN/PAUSE controller
// steps the animation frame index up or down: free-running on slow-clock edges,
// or one frame per step request while paused. Independently, the cube layers
// are scanned one-hot at a fast multiplex rate, with one blank cycle at every
// layer change so that two layers are never lit together.
//
// Ports
//   clk_50MHz_i  system clock, all logic on the rising edge
//   reset_i      synchronous, active-low reset
//   slow_clk_i   toggling slow clock from the divider (asynchronous)
//   run_i        1 = free-run on slow-clock edges, 0 = paused
//   step_req_i   rising edge requests one frame step while paused
//   dir_i        0 = frame index counts up, 1 = counts down
//   frame_idx_o  current animation frame
//   frame_adv_o  one-cycle pulse in the first cycle frame_idx_o shows a new value
//   wrap_o       one-cycle pulse alongside frame_adv_o when the index wrapped
//   layer_idx_o  layer currently being scanned
//   layer_sel_o  one-hot layer enable, all-zero during the blank cycle
// -----------------------------------------------------------------------------
module cube_frame_stepper #(
  parameter int NUM_FRAMES = 8,
  parameter int FRAME_W    = 3,
  parameter int LAYERS     = 4,
  parameter int LAYER_W    = 2,
  parameter int SCAN_DIV   = 12500
) (
  input  logic               clk_50MHz_i,
  input  logic               reset_i,
  input  logic               slow_clk_i,
  input  logic               run_i,
  input  logic               step_req_i,
  input  logic               dir_i,
  output logic [FRAME_W-1:0] frame_idx_o,
  output logic               frame_adv_o,
  output logic               wrap_o,
  output logic [LAYER_W-1:0] layer_idx_o,
  output logic [LAYERS-1:0]  layer_sel_o
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYERS - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_e;

  // ---------------------------------------------------------------------------
  // Slow-clock synchroniser and edge detection
  // ---------------------------------------------------------------------------
  logic       s1_q, s2_q, prev_q;
  logic       armed_q;
  logic [1:0] fill_q;
  logic       step_prev_q;
  logic       slow_edge;
  logic       step_edge;

  // armed_q lets the controller leave IDLE on the first clock after reset.
  // The edge detector waits two more clocks, until prev_q holds a genuine
  // post-reset sample; otherwise a slow clock already high at reset would
  // look like a 0->1 transition as it ripples through the cleared chain.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_50MHz_i) begin
    if (!reset_i) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      prev_q      <= 1'b0;
      armed_q     <= 1'b0;
      fill_q      <= 2'b00;
      step_prev_q <= 1'b0;
    end else begin
      s1_q        <= slow_clk_i;
      s2_q        <= s1_q;
      prev_q      <= s2_q;
      armed_q     <= 1'b1;
      fill_q      <= {fill_q[0], armed_q};
      step_prev_q <= step_req_i;
    end
  end

  assign slow_edge = s2_q & ~prev_q & fill_q[1];
  assign step_edge = step_req_i & ~step_prev_q;

  // ---------------------------------------------------------------------------
  // Frame controller
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;
  logic               frame_adv_q;
  logic               wrap_q, wrap_d;
  logic               advance;

  // A step request arriving in the same cycle run rises is dropped, which
  // the !run_i term handles. Only one advance source is live per state, so at
  // most one advance can happen in any cycle.
  assign advance = ((state_q == RUN)   && slow_edge) ||
                   ((state_q == PAUSE) && step_edge && !run_i);

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    frame_idx_d = frame_idx_q;
    wrap_d      = 1'b0;
    if (advance) begin
      if (!dir_i) begin
        if (frame_idx_q == LAST_FRAME) begin
          frame_idx_d = '0;
          wrap_d      = 1'b1;
        end else begin
          frame_idx_d = frame_idx_q + FRAME_W'(1);
        end
      end else begin
        if (frame_idx_q == '0) begin
          frame_idx_d = LAST_FRAME;
          wrap_d      = 1'b1;
        end else begin
          frame_idx_d = frame_idx_q - FRAME_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      frame_idx_q <= '0;
      frame_adv_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      frame_idx_q <= frame_idx_d;
      frame_adv_q <= advance;
      wrap_q      <= wrap_d;
      case (state_q)
        IDLE:    if (armed_q) state_q <= run_i ? RUN : PAUSE;
        RUN:     if (!run_i)  state_q <= PAUSE;
        PAUSE:   if (run_i)   state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Layer scan: free-running from the first clock after reset
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [LAYER_W-1:0] layer_idx_q, layer_idx_d;
  logic [LAYERS-1:0]  layer_sel_q, layer_sel_d;

  // At terminal count the layer index moves on and the enables blank for that
  // one cycle; in every other cycle the enable tracks the (unchanged) index.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    layer_idx_d = layer_idx_q;
    layer_sel_d = LAYERS'(1) << layer_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      layer_idx_d = (layer_idx_q == LAST_LAYER) ? '0 : layer_idx_q + LAYER_W'(1);
      layer_sel_d = '0;
    end
  end

  always_ff @(posedge clk_50MHz_i) begin
    if (!reset_i) begin
      scan_cnt_q  <= '0;
      layer_idx_q <= '0;
      layer_sel_q <= '0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      layer_idx_q <= layer_idx_d;
      layer_sel_q <= layer_sel_d;
    end
  end

  assign frame_idx_o = frame_idx_q;
  assign frame_adv_o = frame_adv_q;
  assign wrap_o      = wrap_q;
  assign layer_idx_o = layer_idx_q;
  assign layer_sel_o = layer_sel_q;

endmodule
